iob_axi_wr_arbiter: RTL and testbench

Per-manager-port write-path scheduler for the AXI crossbar fabric. It arbitrates AW requests from S_COUNT subordinate-side requesters onto one manager AW channel and drives external mux selects. It records each grant order in a select FIFO so W beats are routed in AW order. It caps outstanding writes at M_ISSUE using B-completion feedback. It carries no payload; it only drives handshakes and selects.

---
 rtl/iob_axi_wr_arbiter_pkg.sv | 51 +++++
 rtl/iob_axi_wr_arbiter_sel_fifo.sv | 51 +++++
 rtl/iob_axi_wr_arbiter.sv | 142 ++++++++++++++
 tb/tb_iob_axi_wr_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/iob_axi_wr_arbiter_pkg.sv
// Shared types and arbitration helpers for the AXI write-path scheduler.
// The optional QoS pre-filter (IOB_AXI_WR_ARB_QOS_EN) uses qos_mask below.
package iob_axi_wr_arbiter_pkg;

  // Widest requester vector the helper functions handle; callers zero-extend.
  localparam int MAX_S = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Round-robin pick: rotate so last+1 sits at bit 0, priority-encode the
  // lowest set bit, then un-rotate back to a requester index.
  // Returns 0 when nothing is requested; callers gate on |req.
  function automatic int rr_pick(input logic [MAX_S-1:0] req,
                                 input int n,
                                 input int last);
    logic [MAX_S-1:0] rot;
    int               hit;
    int               win;
    rot = '0;
    for (int i = 0; i < MAX_S; i++) begin
      if (i < n) rot[i] = req[(last + 1 + i) % n];
    end
    hit = -1;
    for (int i = MAX_S - 1; i >= 0; i--) begin
      if (rot[i]) hit = i;
    end
    win = (hit < 0) ? 0 : (last + 1 + hit) % n;
    return win;
  endfunction

  // Keep only valid requesters whose 4-bit QoS equals the highest valid QoS.
  function automatic logic [MAX_S-1:0] qos_mask(input logic [MAX_S-1:0]   valid,
                                                input logic [4*MAX_S-1:0] qos,
                                                input int n);
    logic [3:0]       top;
    logic [MAX_S-1:0] mask;
    top  = 4'h0;
    mask = '0;
    for (int i = 0; i < MAX_S; i++) begin
      if (i < n && valid[i] && qos[4*i +: 4] > top) top = qos[4*i +: 4];
    end
    for (int i = 0; i < MAX_S; i++) begin
      mask[i] = (i < n) && valid[i] && (qos[4*i +: 4] == top);
    end
    return mask;
  endfunction

endpackage

// File: rtl/iob_axi_wr_arbiter_sel_fifo.sv
// Small select FIFO recording AW grant order so W bursts follow it.
// Pop is evaluated before push, so a full FIFO accepts a push only
// in a cycle that also pops.
module iob_axi_wr_arbiter_sel_fifo
  import iob_axi_wr_arbiter_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             pop_ok;
  logic             push_ok;

  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign dout    = mem[rd_ptr_reg[AW-1:0]];

  // Storage write; contents need no reset since empty gates the head.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg[AW-1:0]] <= din;
  end

  // Pointer update; the extra MSB distinguishes full from empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

endmodule

// File: rtl/iob_axi_wr_arbiter.sv
// Per-manager-port AXI write scheduler: round-robin AW arbitration, W
// routing in AW grant order, and an outstanding-write cap fed by B.
// Optional macro IOB_AXI_WR_ARB_QOS_EN restricts arbitration to the
// highest-QoS valid requesters before round-robin is applied.
module iob_axi_wr_arbiter
  import iob_axi_wr_arbiter_pkg::*;
#(
  parameter  int S_COUNT      = 4,
  parameter  int M_ISSUE      = 4,
  parameter  int W_FIFO_DEPTH = 4,
  localparam int SEL_W        = $clog2(S_COUNT),
  localparam int CNT_W        = $clog2(M_ISSUE + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [S_COUNT-1:0]   s_awvalid,
  input  logic [4*S_COUNT-1:0] s_awqos,
  output logic [S_COUNT-1:0]   s_awready,
  output logic                 m_awvalid,
  input  logic                 m_awready,
  output logic [SEL_W-1:0]     aw_sel,
  input  logic [S_COUNT-1:0]   s_wvalid,
  input  logic [S_COUNT-1:0]   s_wlast,
  output logic [S_COUNT-1:0]   s_wready,
  output logic                 m_wvalid,
  input  logic                 m_wready,
  output logic [SEL_W-1:0]     w_sel,
  input  logic                 b_done,
  output logic [CNT_W-1:0]     issue_cnt,
  output logic                 err
);

  state_t           state_reg;
  state_t           state_next;
  logic [SEL_W-1:0] aw_sel_reg;
  logic [SEL_W-1:0] last_grant_reg;
  logic [CNT_W-1:0] issue_cnt_reg;
  logic             err_reg;

  logic [MAX_S-1:0] cand;
  int               winner;
  logic             arb_en;
  logic             aw_hs;
  logic             w_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [SEL_W-1:0] fifo_head;

`ifdef IOB_AXI_WR_ARB_QOS_EN
  assign cand = qos_mask(MAX_S'(s_awvalid), (4*MAX_S)'(s_awqos), S_COUNT);
`else
  logic unused_qos;
  assign unused_qos = ^s_awqos;
  assign cand       = MAX_S'(s_awvalid);
`endif

  // The registered full flag makes the FIFO check conservative by a cycle.
  assign winner = rr_pick(cand, S_COUNT, int'(last_grant_reg));
  assign arb_en = (|s_awvalid) && (issue_cnt_reg < CNT_W'(M_ISSUE)) && !fifo_full;
  assign aw_hs  = (state_reg == GRANT) && m_awready;

  assign aw_sel    = aw_sel_reg;
  assign issue_cnt = issue_cnt_reg;
  assign err       = err_reg;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next state and AW handshake outputs; a grant is held until accepted.
  always_comb begin
    state_next = state_reg;
    m_awvalid  = 1'b0;
    s_awready  = '0;
    case (state_reg)
      IDLE: begin
        if (arb_en) state_next = GRANT;
      end
      GRANT: begin
        m_awvalid             = 1'b1;
        s_awready[aw_sel_reg] = m_awready;
        if (m_awready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Capture the winner on entry to GRANT; advance the round-robin pointer on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_sel_reg     <= '0;
      last_grant_reg <= SEL_W'(S_COUNT - 1);
    end else begin
      if (state_reg == IDLE && arb_en) aw_sel_reg <= SEL_W'(winner);
      if (aw_hs) last_grant_reg <= aw_sel_reg;
    end
  end

  // Outstanding-write counter; a B completion with nothing outstanding is an error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_cnt_reg <= '0;
      err_reg       <= 1'b0;
    end else begin
      case ({aw_hs, b_done})
        2'b10: issue_cnt_reg <= issue_cnt_reg + CNT_W'(1);
        2'b01: begin
          if (issue_cnt_reg == '0) err_reg <= 1'b1;
          else issue_cnt_reg <= issue_cnt_reg - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // W routing follows the FIFO head; an empty FIFO stalls every requester.
  always_comb begin
    w_sel    = fifo_empty ? '0 : fifo_head;
    m_wvalid = !fifo_empty && s_wvalid[w_sel];
    s_wready = '0;
    if (!fifo_empty) s_wready[w_sel] = m_wready;
  end

  assign w_pop = m_wvalid && m_wready && s_wlast[w_sel];

  iob_axi_wr_arbiter_sel_fifo #(
    .WIDTH (SEL_W),
    .DEPTH (W_FIFO_DEPTH)
  ) u_sel_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (aw_hs),
    .din   (aw_sel_reg),
    .pop   (w_pop),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_iob_axi_wr_arbiter.sv
// Directed self-checking bench for iob_axi_wr_arbiter (default parameters).
// The QoS scenario runs only when IOB_AXI_WR_ARB_QOS_EN is defined.
module tb_iob_axi_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  s_awvalid;
  logic [15:0] s_awqos;
  logic [3:0]  s_awready;
  logic        m_awvalid;
  logic        m_awready;
  logic [1:0]  aw_sel;
  logic [3:0]  s_wvalid;
  logic [3:0]  s_wlast;
  logic [3:0]  s_wready;
  logic        m_wvalid;
  logic        m_wready;
  logic [1:0]  w_sel;
  logic        b_done;
  logic [2:0]  issue_cnt;
  logic        err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  iob_axi_wr_arbiter #(
    .S_COUNT      (4),
    .M_ISSUE      (4),
    .W_FIFO_DEPTH (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_awvalid (s_awvalid),
    .s_awqos   (s_awqos),
    .s_awready (s_awready),
    .m_awvalid (m_awvalid),
    .m_awready (m_awready),
    .aw_sel    (aw_sel),
    .s_wvalid  (s_wvalid),
    .s_wlast   (s_wlast),
    .s_wready  (s_wready),
    .m_wvalid  (m_wvalid),
    .m_wready  (m_wready),
    .w_sel     (w_sel),
    .b_done    (b_done),
    .issue_cnt (issue_cnt),
    .err       (err)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    s_awvalid = 4'b0;
    s_awqos   = 16'h0;
    m_awready = 1'b0;
    s_wvalid  = 4'b0;
    s_wlast   = 4'b0;
    m_wready  = 1'b0;
    b_done    = 1'b0;
  endtask

  task automatic do_reset;
    clear_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset;
    clear_inputs();
    rst_n = 1'b0;
    #2;
    s_awvalid = 4'b1111;
    s_wvalid  = 4'b1111;
    m_wready  = 1'b1;
    m_awready = 1'b1;
    tick();
    tick();
    checks++; if (m_awvalid !== 1'b0) begin errors++; $display("FAIL rst_m_awvalid got=%b exp=0", m_awvalid); end
    checks++; if (s_awready !== 4'b0) begin errors++; $display("FAIL rst_s_awready got=%b exp=0000", s_awready); end
    checks++; if (aw_sel !== 2'd0) begin errors++; $display("FAIL rst_aw_sel got=%0d exp=0", aw_sel); end
    checks++; if (m_wvalid !== 1'b0) begin errors++; $display("FAIL rst_m_wvalid got=%b exp=0", m_wvalid); end
    checks++; if (s_wready !== 4'b0) begin errors++; $display("FAIL rst_s_wready got=%b exp=0000", s_wready); end
    checks++; if (w_sel !== 2'd0) begin errors++; $display("FAIL rst_w_sel got=%0d exp=0", w_sel); end
    checks++; if (issue_cnt !== 3'd0) begin errors++; $display("FAIL rst_issue_cnt got=%0d exp=0", issue_cnt); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err got=%b exp=0", err); end
    $display("reset: state checked");
    do_reset();
  endtask

  task automatic test_rr_grants;
    logic [1:0] exp_sel [4];
    exp_sel[0] = 2'd0; exp_sel[1] = 2'd2; exp_sel[2] = 2'd0; exp_sel[3] = 2'd2;
    do_reset();
    s_awvalid = 4'b0101;
    m_awready = 1'b1;
    #1;
    checks++; if (m_awvalid !== 1'b0) begin errors++; $display("FAIL rr_idle_awvalid got=%b exp=0", m_awvalid); end
    for (int k = 0; k < 4; k++) begin
      tick();
      $display("rr grant %0d: m_awvalid=%b aw_sel=%0d s_awready=%b", k, m_awvalid, aw_sel, s_awready);
      checks++; if (m_awvalid !== 1'b1) begin errors++; $display("FAIL rr_awvalid_hi k=%0d got=%b exp=1", k, m_awvalid); end
      checks++; if (aw_sel !== exp_sel[k]) begin errors++; $display("FAIL rr_aw_sel k=%0d got=%0d exp=%0d", k, aw_sel, exp_sel[k]); end
      checks++; if (s_awready !== (4'b0001 << exp_sel[k])) begin errors++; $display("FAIL rr_s_awready k=%0d got=%b exp=%b", k, s_awready, 4'b0001 << exp_sel[k]); end
      tick();
      checks++; if (m_awvalid !== 1'b0) begin errors++; $display("FAIL rr_awvalid_lo k=%0d got=%b exp=0", k, m_awvalid); end
    end
    checks++; if (issue_cnt !== 3'd4) begin errors++; $display("FAIL rr_issue_cnt got=%0d exp=4", issue_cnt); end
    tick();
    checks++; if (m_awvalid !== 1'b0) begin errors++; $display("FAIL rr_cap_no_grant got=%b exp=0", m_awvalid); end
  endtask

  task automatic test_grant_hold;
    do_reset();
    s_awvalid = 4'b0010;
    m_awready = 1'b0;
    tick();
    for (int k = 0; k < 5; k++) begin
      if (k == 2) s_awvalid = 4'b1010;
      #1;
      checks++; if (m_awvalid !== 1'b1 || aw_sel !== 2'd1) begin errors++; $display("FAIL hold_grant k=%0d got=%b/%0d exp=1/1", k, m_awvalid, aw_sel); end
      checks++; if (s_awready !== 4'b0) begin errors++; $display("FAIL hold_s_awready k=%0d got=%b exp=0000", k, s_awready); end
      tick();
    end
    m_awready = 1'b1;
    #1;
    checks++; if (s_awready !== 4'b0010) begin errors++; $display("FAIL hold_accept_ready got=%b exp=0010", s_awready); end
    tick();
    s_awvalid = 4'b1000;
    checks++; if (issue_cnt !== 3'd1 || m_awvalid !== 1'b0) begin errors++; $display("FAIL hold_after_hs got=%0d/%b exp=1/0", issue_cnt, m_awvalid); end
    tick();
    $display("hold: next grant aw_sel=%0d", aw_sel);
    checks++; if (aw_sel !== 2'd3 || m_awvalid !== 1'b1) begin errors++; $display("FAIL hold_next_grant got=%0d/%b exp=3/1", aw_sel, m_awvalid); end
  endtask

  task automatic test_w_order;
    do_reset();
    m_awready = 1'b1;
    s_awvalid = 4'b0100;
    tick();
    tick();
    s_awvalid = 4'b0001;
    tick();
    tick();
    s_awvalid = 4'b0000;
    s_wvalid  = 4'b0101;
    s_wlast   = 4'b0001;
    m_wready  = 1'b1;
    #1;
    for (int b = 0; b < 3; b++) begin
      if (b == 2) begin
        s_wlast = 4'b0101;
        #1;
      end
      $display("w beat %0d: w_sel=%0d s_wready=%b m_wvalid=%b", b, w_sel, s_wready, m_wvalid);
      checks++; if (w_sel !== 2'd2) begin errors++; $display("FAIL w_sel_r2 beat=%0d got=%0d exp=2", b, w_sel); end
      checks++; if (s_wready !== 4'b0100 || m_wvalid !== 1'b1) begin errors++; $display("FAIL w_ready_r2 beat=%0d got=%b/%b exp=0100/1", b, s_wready, m_wvalid); end
      tick();
    end
    $display("w beat 3: w_sel=%0d s_wready=%b m_wvalid=%b", w_sel, s_wready, m_wvalid);
    checks++; if (w_sel !== 2'd0) begin errors++; $display("FAIL w_sel_r0 got=%0d exp=0", w_sel); end
    checks++; if (s_wready !== 4'b0001 || m_wvalid !== 1'b1) begin errors++; $display("FAIL w_ready_r0 got=%b/%b exp=0001/1", s_wready, m_wvalid); end
    tick();
    s_wvalid = 4'b0000;
    #1;
    checks++; if (m_wvalid !== 1'b0 || s_wready !== 4'b0) begin errors++; $display("FAIL w_empty got=%b/%b exp=0/0000", m_wvalid, s_wready); end
  endtask

  task automatic test_issue_cap;
    do_reset();
    s_awvalid = 4'b1111;
    m_awready = 1'b1;
    s_wvalid  = 4'b1111;
    s_wlast   = 4'b1111;
    m_wready  = 1'b1;
    for (int k = 0; k < 8; k++) tick();
    $display("cap: issue_cnt=%0d m_awvalid=%b", issue_cnt, m_awvalid);
    checks++; if (issue_cnt !== 3'd4 || m_awvalid !== 1'b0) begin errors++; $display("FAIL cap_full got=%0d/%b exp=4/0", issue_cnt, m_awvalid); end
    tick();
    checks++; if (m_awvalid !== 1'b0) begin errors++; $display("FAIL cap_blocked got=%b exp=0", m_awvalid); end
    b_done = 1'b1;
    tick();
    b_done = 1'b0;
    checks++; if (issue_cnt !== 3'd3 || m_awvalid !== 1'b0) begin errors++; $display("FAIL cap_bdone got=%0d/%b exp=3/0", issue_cnt, m_awvalid); end
    tick();
    checks++; if (m_awvalid !== 1'b1 || aw_sel !== 2'd0) begin errors++; $display("FAIL cap_regrant got=%b/%0d exp=1/0", m_awvalid, aw_sel); end
    b_done = 1'b1;
    tick();
    b_done = 1'b0;
    $display("cap: aw+b same cycle issue_cnt=%0d", issue_cnt);
    checks++; if (issue_cnt !== 3'd3) begin errors++; $display("FAIL cap_both got=%0d exp=3", issue_cnt); end
  endtask

  task automatic test_err;
    do_reset();
    b_done = 1'b1;
    tick();
    b_done = 1'b0;
    checks++; if (err !== 1'b1 || issue_cnt !== 3'd0) begin errors++; $display("FAIL err_set got=%b/%0d exp=1/0", err, issue_cnt); end
    tick();
    tick();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky got=%b exp=1", err); end
    rst_n = 1'b0;
    #1;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_async_clear got=%b exp=0", err); end
    $display("err: cleared by reset");
    do_reset();
  endtask

`ifdef IOB_AXI_WR_ARB_QOS_EN
  task automatic test_qos;
    logic [1:0] exp_sel [4];
    exp_sel[0] = 2'd1; exp_sel[1] = 2'd2; exp_sel[2] = 2'd1; exp_sel[3] = 2'd2;
    do_reset();
    s_awqos   = 16'h1882;
    s_awvalid = 4'b1111;
    m_awready = 1'b1;
    s_wvalid  = 4'b1111;
    s_wlast   = 4'b1111;
    m_wready  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      $display("qos grant %0d: aw_sel=%0d", k, aw_sel);
      checks++; if (m_awvalid !== 1'b1 || aw_sel !== exp_sel[k]) begin errors++; $display("FAIL qos_grant k=%0d got=%b/%0d exp=1/%0d", k, m_awvalid, aw_sel, exp_sel[k]); end
      tick();
    end
  endtask
`endif

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    test_reset();
    test_rr_grants();
    test_grant_hold();
    test_w_order();
    test_issue_cap();
    test_err();
`ifdef IOB_AXI_WR_ARB_QOS_EN
    test_qos();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
